// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encoding and
// the static mapping of shift-network levels onto register stages.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROL = 2'd3
  } op_e;

  // Ceiling log2, never below 1 so a 2-bit datapath still has one level.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Register stage that owns shift level k.
  function automatic int stage_of_level(input int k, input int levels, input int stages);
    return (k * stages) / levels;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One mux level of the shift network: optionally shifts/rotates by a fixed
// power-of-two amount, using a carried fill bit for arithmetic right shifts.
module barrel_shift_level
  import barrel_shift_pkg::*;
#(
  parameter int width  = 8,
  parameter int amount = 1
) (
  input  logic [width-1:0] data_i,
  input  logic             en_i,
  input  op_e              op_i,
  input  logic             fill_i,
  output logic [width-1:0] data_o
);

  localparam logic [width-1:0] FILL_MASK = ~({width{1'b1}} >> amount);

  always_comb begin
    // NOTE: output defaults first so every path assigns it and no latch is inferred.
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = data_i << amount;
        OP_SRL:  data_o = data_i >> amount;
        OP_SRA:  data_o = (data_i >> amount) | (FILL_MASK & {width{fill_i}});
        OP_ROL:  data_o = (data_i << amount) | (data_i >> (width - amount));
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined multi-mode barrel shifter with a stall-all valid/ready pipeline;
// the log2 shift network is spread across `stages` register stages.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter int width  = 8,
  parameter int stages = 1,
  localparam int SW    = clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_bits,
  input  logic [SW-1:0]    i_shift,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_bits
);

  localparam int          LEVELS = SW;
  localparam logic [SW:0] W_EXT  = (SW + 1)'(width);

  logic          en;
  logic [SW-1:0] shift_in;

  // Values presented to the levels of each stage (input port or previous register).
  logic [width-1:0] src_data  [stages];
  logic [SW-1:0]    src_shift [stages];
  op_e              src_op    [stages];
  logic             src_fill  [stages];
  logic             src_valid [stages];

  logic [width-1:0] lvl_in  [LEVELS];
  logic [width-1:0] lvl_out [LEVELS];

  logic [width-1:0] data_d  [stages];
  logic [width-1:0] data_q  [stages];
  logic [SW-1:0]    shift_q [stages];
  op_e              op_q    [stages];
  logic             fill_q  [stages];
  logic             valid_q [stages];

  assign o_valid = valid_q[stages-1];
  assign o_bits  = data_q[stages-1];
  assign en      = !o_valid || o_ready;
  assign i_ready = en;

  // Rotation is reduced mod width up front; amounts here are below 2*width.
  always_comb begin
    shift_in = i_shift;
    if (op_e'(i_op) == OP_ROL && {1'b0, i_shift} >= W_EXT) begin
      shift_in = i_shift - W_EXT[SW-1:0];
    end
  end

  for (genvar s = 0; s < stages; s++) begin : g_src
    if (s == 0) begin : g_head
      assign src_data[s]  = i_bits;
      assign src_shift[s] = shift_in;
      assign src_op[s]    = op_e'(i_op);
      assign src_fill[s]  = i_bits[width-1];
      assign src_valid[s] = i_valid && i_ready;
    end else begin : g_body
      assign src_data[s]  = data_q[s-1];
      assign src_shift[s] = shift_q[s-1];
      assign src_op[s]    = op_q[s-1];
      assign src_fill[s]  = fill_q[s-1];
      assign src_valid[s] = valid_q[s-1];
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int S     = stage_of_level(k, LEVELS, stages);
    localparam bit FIRST = (k == 0) ? 1'b1 : (stage_of_level(k - 1, LEVELS, stages) != S);
    localparam bit LAST  = (k == LEVELS - 1) ? 1'b1 : (stage_of_level(k + 1, LEVELS, stages) != S);

    if (FIRST) begin : g_first
      assign lvl_in[k] = src_data[S];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    barrel_shift_level #(
      .width (width),
      .amount(1 << k)
    ) u_level (
      .data_i(lvl_in[k]),
      .en_i  (src_shift[S][k]),
      .op_i  (src_op[S]),
      .fill_i(src_fill[S]),
      .data_o(lvl_out[k])
    );

    if (LAST) begin : g_last
      assign data_d[S] = lvl_out[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < stages; s++) begin
        // NOTE: data registers are reset as well so o_bits reads 0 straight out of reset.
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        shift_q[s] <= '0;
        op_q[s]    <= OP_SLL;
        fill_q[s]  <= 1'b0;
      end
    end else if (en) begin
      for (int s = 0; s < stages; s++) begin
        // NOTE: non-blocking so every stage loads its predecessor's pre-edge value.
        valid_q[s] <= src_valid[s];
        data_q[s]  <= data_d[s];
        shift_q[s] <= src_shift[s];
        op_q[s]    <= src_op[s];
        fill_q[s]  <= src_fill[s];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: four configurations, scoreboard
// queues filled at acceptance and drained by a negedge monitor.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: width 8, 1 stage
  logic a_iv, a_or; logic [7:0] a_ib; logic [2:0] a_ish; logic [1:0] a_iop;
  logic a_ir, a_ov; logic [7:0] a_ob;
  // Instance B: width 12, 2 stages
  logic b_iv, b_or; logic [11:0] b_ib; logic [3:0] b_ish; logic [1:0] b_iop;
  logic b_ir, b_ov; logic [11:0] b_ob;
  // Instance C: width 16, 4 stages
  logic c_iv, c_or; logic [15:0] c_ib; logic [3:0] c_ish; logic [1:0] c_iop;
  logic c_ir, c_ov; logic [15:0] c_ob;
  // Instance D: width 8, 3 stages
  logic d_iv, d_or; logic [7:0] d_ib; logic [2:0] d_ish; logic [1:0] d_iop;
  logic d_ir, d_ov; logic [7:0] d_ob;

  barrel_shift_pipe #(.width(8), .stages(1)) u_a (
    .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir), .i_bits(a_ib), .i_shift(a_ish),
    .i_op(a_iop), .o_valid(a_ov), .o_ready(a_or), .o_bits(a_ob));
  barrel_shift_pipe #(.width(12), .stages(2)) u_b (
    .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir), .i_bits(b_ib), .i_shift(b_ish),
    .i_op(b_iop), .o_valid(b_ov), .o_ready(b_or), .o_bits(b_ob));
  barrel_shift_pipe #(.width(16), .stages(4)) u_c (
    .clk(clk), .rst(rst), .i_valid(c_iv), .i_ready(c_ir), .i_bits(c_ib), .i_shift(c_ish),
    .i_op(c_iop), .o_valid(c_ov), .o_ready(c_or), .o_bits(c_ob));
  barrel_shift_pipe #(.width(8), .stages(3)) u_d (
    .clk(clk), .rst(rst), .i_valid(d_iv), .i_ready(d_ir), .i_bits(d_ib), .i_shift(d_ish),
    .i_op(d_iop), .o_valid(d_ov), .o_ready(d_or), .o_bits(d_ob));

  int stg[4] = '{1, 2, 4, 3};

  typedef struct {
    logic [15:0] data;
    int          exp_cyc;
  } sb_t;

  sb_t         sbq[4][$];
  int          xfer[4];
  logic        hold_v[4];
  logic [15:0] hold_b[4];
  logic        toggle_en = 1'b0;
  int          tog_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input int id);
    case (id)
      0: return a_ov;
      1: return b_ov;
      2: return c_ov;
      default: return d_ov;
    endcase
  endfunction

  function automatic logic get_ir(input int id);
    case (id)
      0: return a_ir;
      1: return b_ir;
      2: return c_ir;
      default: return d_ir;
    endcase
  endfunction

  function automatic logic get_or(input int id);
    case (id)
      0: return a_or;
      1: return b_or;
      2: return c_or;
      default: return d_or;
    endcase
  endfunction

  function automatic logic [15:0] get_ob(input int id);
    case (id)
      0: return 16'(a_ob);
      1: return 16'(b_ob);
      2: return c_ob;
      default: return 16'(d_ob);
    endcase
  endfunction

  task automatic drive_in(input int id, input logic v, input logic [15:0] b, input int sh, input int op);
    case (id)
      0: begin a_iv = v; a_ib = b[7:0];  a_ish = 3'(sh); a_iop = 2'(op); end
      1: begin b_iv = v; b_ib = b[11:0]; b_ish = 4'(sh); b_iop = 2'(op); end
      2: begin c_iv = v; c_ib = b;       c_ish = 4'(sh); c_iop = 2'(op); end
      default: begin d_iv = v; d_ib = b[7:0]; d_ish = 3'(sh); d_iop = 2'(op); end
    endcase
  endtask

  // Bit-by-bit reference: each result bit picks its source bit directly.
  function automatic logic [15:0] ref_model(input int w, input logic [15:0] d, input int sh, input int op);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        0: r[i] = (i - sh >= 0) ? d[i-sh] : 1'b0;
        1: r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        2: r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        default: r[i] = d[(i - (sh % w) + w) % w];
      endcase
    end
    return r;
  endfunction

  // Output monitor: handshake rule, hold stability, and in-order scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      for (int id = 0; id < 4; id++) begin
        check($sformatf("i_ready_rule_%0d", id), 32'(get_ir(id)), 32'(!get_ov(id) || get_or(id)));
        if (hold_v[id] && get_ov(id)) begin
          check($sformatf("o_bits_stable_%0d", id), 32'(get_ob(id)), 32'(hold_b[id]));
        end
        hold_v[id] = get_ov(id) && !get_or(id);
        hold_b[id] = get_ob(id);
        if (get_ov(id) && get_or(id)) begin
          xfer[id]++;
          check($sformatf("beat_expected_%0d", id), 32'(sbq[id].size() > 0), 32'd1);
          if (sbq[id].size() > 0) begin
            e = sbq[id].pop_front();
            check($sformatf("o_bits_%0d", id), 32'(get_ob(id)), 32'(e.data));
            if (e.exp_cyc >= 0) check($sformatf("latency_%0d", id), 32'(cyc), 32'(e.exp_cyc));
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      c_or = (tog_cnt % 3 == 0);
      tog_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int id, input logic [15:0] b, input int sh, input int op,
                      input logic [15:0] exp, input bit chk_lat);
    logic ok;
    sb_t  e;
    ok = 1'b0;
    drive_in(id, 1'b1, b, sh, op);
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = get_ir(id);
    end
    check($sformatf("accept_%0d", id), 32'(ok), 32'd1);
    if (ok) begin
      e.data    = exp;
      e.exp_cyc = chk_lat ? cyc + stg[id] : -1;
      sbq[id].push_back(e);
    end
    @(posedge clk);
    #1;
    drive_in(id, 1'b0, 16'h0, 0, 0);
  endtask

  task automatic wait_drain(input int id);
    for (int t = 0; t < 200 && sbq[id].size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    check($sformatf("drain_%0d", id), 32'(sbq[id].size()), 32'd0);
    tick(1);
  endtask

  logic [15:0] exp1[4] = '{16'hA0, 16'h16, 16'hF6, 16'hA5};
  logic [15:0] exp2[4] = '{16'h000, 16'h000, 16'hFFF, 16'h003};

  initial begin
    logic [15:0] rb;
    int          rs, ro, x0;

    for (int id = 0; id < 4; id++) begin
      drive_in(id, 1'b0, 16'h0, 0, 0);
      hold_v[id] = 1'b0;
      xfer[id]   = 0;
    end
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1; d_or = 1'b1;
    rst = 1'b1;

    // Reset state
    #1;
    for (int id = 0; id < 4; id++) begin
      check($sformatf("reset_o_valid_%0d", id), 32'(get_ov(id)), 32'd0);
      check($sformatf("reset_o_bits_%0d", id), 32'(get_ob(id)), 32'd0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    tick(1);
    for (int id = 0; id < 4; id++) check($sformatf("reset_i_ready_%0d", id), 32'(get_ir(id)), 32'd1);

    // Width 8, 1 stage: every op on 0xB4 by 3
    for (int op = 0; op < 4; op++) send(0, 16'hB4, 3, op, exp1[op], 1'b1);
    // Shift of 0 passes through; ROL by 7
    for (int op = 0; op < 4; op++) send(0, 16'h5A, 0, op, 16'h5A, 1'b1);
    send(0, 16'h01, 7, 3, 16'h80, 1'b1);
    wait_drain(0);

    // Width 12, 2 stages: out-of-range amount 13
    for (int op = 0; op < 4; op++) send(1, 16'h801, 13, op, exp2[op], 1'b1);
    wait_drain(1);

    // Width 16, 4 stages: random back-to-back beats under toggling backpressure
    toggle_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rb = 16'($urandom_range(0, 65535));
      rs = int'($urandom_range(0, 15));
      ro = int'($urandom_range(0, 3));
      send(2, rb, rs, ro, ref_model(16, rb, rs, ro), 1'b0);
    end
    wait_drain(2);
    toggle_en = 1'b0;
    tick(1);
    c_or = 1'b1;
    tick(1);

    // Full stall on width 8, 3 stages
    d_or = 1'b0;
    send(3, 16'h96, 5, 2, ref_model(8, 16'h96, 5, 2), 1'b0);
    send(3, 16'h3C, 2, 3, ref_model(8, 16'h3C, 2, 3), 1'b0);
    send(3, 16'hF1, 4, 1, ref_model(8, 16'hF1, 4, 1), 1'b0);
    drive_in(3, 1'b1, 16'h81, 1, 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("stall_i_ready", 32'(d_ir), 32'd0);
      check("stall_o_valid", 32'(d_ov), 32'd1);
    end
    @(posedge clk);
    #1;
    d_or = 1'b1;
    x0 = xfer[3];
    @(negedge clk);
    check("release_i_ready", 32'(d_ir), 32'd1);
    begin
      sb_t e;
      e.data    = ref_model(8, 16'h81, 1, 0);
      e.exp_cyc = cyc + stg[3];
      sbq[3].push_back(e);
    end
    @(posedge clk);
    #1;
    drive_in(3, 1'b0, 16'h0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("drain_one_per_cycle", 32'(xfer[3] - x0), 32'd4);
    wait_drain(3);

    // Reset with three beats in flight
    d_or = 1'b0;
    send(3, 16'h12, 1, 0, ref_model(8, 16'h12, 1, 0), 1'b0);
    send(3, 16'h34, 2, 1, ref_model(8, 16'h34, 2, 1), 1'b0);
    send(3, 16'hC6, 3, 2, ref_model(8, 16'hC6, 3, 2), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_o_valid", 32'(d_ov), 32'd0);
    check("mid_reset_o_bits", 32'(d_ob), 32'd0);
    sbq[3].delete();
    for (int id = 0; id < 4; id++) hold_v[id] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    d_or = 1'b1;
    tick(5);
    check("post_reset_empty", 32'(d_ov), 32'd0);
    check("post_reset_i_ready", 32'(d_ir), 32'd1);
    send(3, 16'hA7, 6, 3, ref_model(8, 16'hA7, 6, 3), 1'b1);
    wait_drain(3);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
Generic, pipelined multi-mode barrel shifter: the parametrised successor of the combinational left shifter.
- Supports four operations: logical left, logical right, arithmetic right and rotate left.
- Splits the log2 shift network across a configurable number of register stages.
- Carries a valid/ready handshake with full backpressure.
- Sits in datapaths feeding ALU and bit-manipulation units.

Parameters:
width, 8, data width in bits; must be >= 2; need not be a power of 2
stages, 1, register stages in the pipeline; 1 <= stages <= clog2(width); latency equals stages

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input beat valid
i_ready  out  1  input beat accepted when i_valid && i_ready
i_bits  in  width  data to shift
i_shift  in  clog2(width)  shift amount
i_op  in  2  operation: 0=SLL, 1=SRL, 2=SRA, 3=ROL
o_valid  out  1  output beat valid
o_ready  in  1  downstream accepts when o_valid && o_ready
o_bits  out  width  shifted result

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: all stage valid flags go to 0 immediately, giving o_valid=0. Data registers are reset to 0, so o_bits=0. i_ready follows the rule below, so it is 1 once reset deasserts.
- Shift network:
  - Level k (k=0..clog2(width)-1) shifts by 2^k when bit k of the shift amount is 1.
  - Level k is assigned to register stage floor(k*stages/clog2(width)).
  - Each register stage holds the partial data, the remaining shift bits, the op and a valid flag.
- Shift amount semantics:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original i_bits[width-1], carried through every stage.
  - ROL: rotate by i_shift mod width.
- Out-of-range amounts (non-power-of-2 width, i_shift >= width):
  - SLL and SRL give all zeros.
  - SRA gives all sign bits.
  - ROL uses i_shift mod width, computed combinationally before level 0.
- Shift amount 0 passes data unchanged for every op.
- Latency: a beat accepted at edge N appears on o_bits/o_valid after edge N+stages-1. With stages=1 it appears the cycle after acceptance.
- Throughput: one beat per cycle when o_ready stays 1.
- Backpressure: the pipeline is stall-all.
  - Global advance enable en = !o_valid || o_ready.
  - i_ready = en; there is no combinational path from i_valid to i_ready.
  - When en=0, every stage holds data and valid unchanged.
  - When en=1, each stage loads from its predecessor. Stage 0 loads i_valid && i_ready.
  - Bubbles are not squeezed out while stalled; they are filled only on advance.
- Handshake rules:
  - Once o_valid=1, o_bits must stay stable until accepted.
  - Simultaneous o_ready=1 with a new input beat: output and input transfer in the same cycle.
- Reset mid-operation: all in-flight beats are discarded and no partial beat is emitted. After deassertion the pipeline is empty.
- i_op, i_shift and i_bits are sampled only at acceptance. Changing them while i_ready=0 has no effect.

Decomposition:
- Shared package barrel_shift_pkg holds:
  - op encoding constants OP_SLL=0, OP_SRL=1, OP_SRA=2, OP_ROL=3;
  - the function stage_of_level(k, levels, stages);
  - the use of the common clog2 helper.
- One sub-module barrel_shift_level (parameters width, amount=2^k): purely combinational single mux level taking data, enable bit, op and fill bit.
- Top module instantiates clog2(width) levels and inserts stage registers per stage_of_level.

Test Plan:
1. width=8, stages=1, o_ready=1: i_bits=0xB4, i_shift=3, each op. Expected one cycle later: SLL->0xA0, SRL->0x16, SRA->0xF6, ROL->0xA5.
2. width=12, stages=2: i_bits=0x801, i_shift=13. Expected: SLL->0x000, SRL->0x000, SRA->0xFFF, ROL (13 mod 12=1)->0x003; each o_valid exactly 2 cycles after acceptance.
3. width=16, stages=4, back-to-back: 20 random beats with o_ready toggling 1,0,0,1,... Results must match the reference model in order, with no drop or duplicate. o_bits must be stable while o_valid && !o_ready, and i_ready must equal !o_valid || o_ready.
4. Shift 0 for all ops on 0x5A (width=8): output 0x5A each time. Shift 7 ROL on 0x01: output 0x80.
5. Reset mid-stream: width=8, stages=3, three beats in flight, assert rst asynchronously between edges. Expected: o_valid drops to 0 immediately and o_bits=0. After release, no stale beat appears, and the next accepted beat emerges after 3 cycles.
6. Full stall: hold o_ready=0 with the pipeline full. Expected: i_ready=0 and no beat accepted despite i_valid=1. Raise o_ready: one beat drains per cycle and the input is accepted in the same cycle.
